ifetch_ctrl: RTL and testbench
==============================

Name: ifetch_ctrl

Overview:
- Fetch-stage controller directly downstream of the PC register.
- Takes the current PC, runs one instruction-bus transaction per PC, and presents {pc, instr} to decode with a valid/ready handshake.
- Drives the PC register's advance enable.
- Discards in-flight or held fetches on a pipeline redirect.

Parameters:
- RESET_PC, 64'h8000_0000, PC value driven on dec_pc_o while no instruction is held.
- NOP_INSTR, 32'h0000_0013, instruction value substituted on a faulted fetch (addi x0,x0,0).

Ports:
- clk  in  1  clock
- reset  in  1  reset (see Behaviour)
- pc_i  in  64  current PC from the PC register
- pc_advance_o  out  1  PC register loads pc+4 only when high
- redirect_i  in  1  one-cycle flush; PC register loads the target at this edge
- ireq_valid_o  out  1  instruction-bus request valid
- ireq_addr_o  out  64  instruction-bus address
- iresp_data_ok_i  in  1  response valid, one cycle
- iresp_data_i  in  32  instruction word
- dec_valid_o  out  1  decode-side valid
- dec_ready_i  in  1  decode-side ready
- dec_pc_o  out  64  PC of the held instruction
- dec_instr_o  out  32  held instruction
- dec_exc_o  out  1  instruction-address-misaligned flag

Behaviour:
- Reset: reset and clock are already decided as "reset reset, synchronous, active-high; clock clk". Reset state is IDLE, with these outputs:
  - ireq_valid_o=0, pc_advance_o=0, dec_valid_o=0, dec_exc_o=0
  - dec_pc_o=RESET_PC, dec_instr_o=0, ireq_addr_o=0
  - Reset mid-transaction returns to IDLE. The bus is reset by the same signal, so no stale response is expected.
- State IDLE:
  - redirect_i=1: stay IDLE.
  - Otherwise: req_pc<=pc_i, go to REQ.
- State REQ:
  - Outputs: ireq_valid_o=1, ireq_addr_o=req_pc. Address is held stable until data_ok.
  - data_ok=1 and redirect_i=0: capture instr, go to HOLD, pc_advance_o=1 combinationally in this cycle. dec_valid_o rises next cycle (latency 1 from data_ok).
  - data_ok=1 and redirect_i=1: drop the response, pc_advance_o=0, go to IDLE.
  - data_ok=0 and redirect_i=1: go to DISCARD.
- State DISCARD:
  - ireq_valid_o stays 1 with the same address, because a request cannot be withdrawn.
  - On data_ok: drop the response, go to IDLE. redirect_i is ignored here.
  - No dec_valid_o and no pc_advance_o while in DISCARD.
- State HOLD:
  - Outputs: dec_valid_o=1, with dec_pc_o/dec_instr_o stable until accepted.
  - redirect_i=1: go to IDLE. This has priority over the handshake. The instruction is not delivered and dec_valid_o=0 next cycle.
  - dec_ready_i=1: req_pc<=pc_i, go to REQ. Back-to-back fetch; peak throughput is 1 instruction per 2 cycles with 1-cycle memory.
  - dec_ready_i=0: hold.
- pc_advance_o is a single-cycle pulse, exactly once per delivered fetch, and never in the same cycle as redirect_i.
- dec_exc_o is 0 unless the optional feature is compiled in.

Optional Feature:
- Macro: IFETCH_MISALIGN_CHECK_EN.
- Defined: in IDLE (and in HOLD on handshake), if pc_i[1:0]!=0 then:
  - skip the bus request;
  - go directly to HOLD with dec_instr_o=NOP_INSTR, dec_exc_o=1, dec_pc_o=pc_i;
  - pc_advance_o=0;
  - decode or the exception logic is responsible for redirecting.
- Not defined: no alignment check; dec_exc_o is tied 0; the address is issued as-is.

Test Plan:
- Basic fetch: reset 2 cycles, pc_i=0x8000_0000, data_ok after 3 cycles with 0x00500093 -> ireq_addr_o=0x8000_0000 held for all 3 cycles; pc_advance_o pulses once; next cycle dec_valid_o=1, dec_instr_o=0x00500093, dec_pc_o=0x8000_0000.
- Decode stall: hold dec_ready_i=0 for 5 cycles in HOLD -> outputs stable; no new request; no pc_advance; on ready, a new request issues to 0x8000_0004 next cycle.
- Redirect during REQ: redirect_i pulse 1 cycle before data_ok, pc_i then 0x8000_0100 -> response dropped; dec_valid_o never rises; next request address is 0x8000_0100; no pc_advance for the dropped fetch.
- Redirect in HOLD with dec_ready_i=1 same cycle -> not delivered; IDLE then REQ to the target.
- Reset mid-REQ, with data_ok arriving in the reset cycle -> IDLE; all outputs at reset values; dec_valid_o=0.
- With IFETCH_MISALIGN_CHECK_EN: pc_i=0x8000_0002 -> no ireq_valid_o; dec_valid_o=1, dec_exc_o=1, dec_instr_o=0x00000013; pc_advance_o=0.

Source files
------------

// File: rtl/ifetch_ctrl.sv
// Fetch-stage controller: one bus transaction per PC, held for decode.
// Optional alignment check: IFETCH_MISALIGN_CHECK_EN.
module ifetch_ctrl #(
  parameter logic [63:0] RESET_PC  = 64'h8000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_i,
  output logic        pc_advance_o,
  input  logic        redirect_i,
  output logic        ireq_valid_o,
  output logic [63:0] ireq_addr_o,
  input  logic        iresp_data_ok_i,
  input  logic [31:0] iresp_data_i,
  output logic        dec_valid_o,
  input  logic        dec_ready_i,
  output logic [63:0] dec_pc_o,
  output logic [31:0] dec_instr_o,
  output logic        dec_exc_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD,
    HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        exc_q, exc_d;
  logic        start;
  logic        misal;

`ifdef IFETCH_MISALIGN_CHECK_EN
  assign misal = (pc_i[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    exc_d        = exc_q;
    start        = 1'b0;
    ireq_valid_o = 1'b0;
    pc_advance_o = 1'b0;
    dec_valid_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!redirect_i) start = 1'b1;
      end
      REQ: begin
        ireq_valid_o = 1'b1;
        if (iresp_data_ok_i) begin
          if (!redirect_i) begin
            state_d      = HOLD;
            instr_d      = iresp_data_i;
            exc_d        = 1'b0;
            pc_advance_o = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (redirect_i) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        // A request cannot be withdrawn; wait out its response.
        ireq_valid_o = 1'b1;
        if (iresp_data_ok_i) state_d = IDLE;
      end
      HOLD: begin
        dec_valid_o = 1'b1;
        if (redirect_i) state_d = IDLE;
        else if (dec_ready_i) start = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      pc_d = pc_i;
      if (misal) begin
        state_d = HOLD;
        instr_d = NOP_INSTR;
        exc_d   = 1'b1;
      end else begin
        state_d = REQ;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      exc_q   <= exc_d;
    end
  end

  assign ireq_addr_o = pc_q;
  assign dec_pc_o    = (state_q == HOLD) ? pc_q : RESET_PC;
  assign dec_instr_o = instr_q;
  assign dec_exc_o   = exc_q & (state_q == HOLD);

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios plus randomized run
// against a transaction-level model of fetch, memory and PC register.
module tb_ifetch_ctrl;

  localparam logic [63:0] RPC = 64'h8000_0000;
  localparam logic [63:0] A   = 64'h8000_0000;
  localparam logic [31:0] INS = 32'h0050_0093;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] pc_i = '0;
  logic        pc_advance_o;
  logic        redirect_i = 1'b0;
  logic        ireq_valid_o;
  logic [63:0] ireq_addr_o;
  logic        iresp_data_ok_i = 1'b0;
  logic [31:0] iresp_data_i = '0;
  logic        dec_valid_o;
  logic        dec_ready_i = 1'b0;
  logic [63:0] dec_pc_o;
  logic [31:0] dec_instr_o;
  logic        dec_exc_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ifetch_ctrl dut (
    .clk(clk),
    .reset(reset),
    .pc_i(pc_i),
    .pc_advance_o(pc_advance_o),
    .redirect_i(redirect_i),
    .ireq_valid_o(ireq_valid_o),
    .ireq_addr_o(ireq_addr_o),
    .iresp_data_ok_i(iresp_data_ok_i),
    .iresp_data_i(iresp_data_i),
    .dec_valid_o(dec_valid_o),
    .dec_ready_i(dec_ready_i),
    .dec_pc_o(dec_pc_o),
    .dec_instr_o(dec_instr_o),
    .dec_exc_o(dec_exc_o)
  );

  function automatic logic [31:0] mem(input logic [63:0] a);
    return {a[31:2], 2'b11} ^ 32'hA5A5_0000;
  endfunction

  task automatic cyc(input logic r, input logic [63:0] pc,
                     input logic redir, input logic dok,
                     input logic [31:0] d, input logic rdy);
    @(negedge clk);
    reset = r;
    pc_i = pc;
    redirect_i = redir;
    iresp_data_ok_i = dok;
    iresp_data_i = d;
    dec_ready_i = rdy;
    #1;
  endtask

  task automatic test_reset();
    cyc(1, A, 0, 0, 0, 0);
    cyc(1, A, 0, 0, 0, 0);
    total += 7;
    if (ireq_valid_o !== 1'b0) begin
      bad++; $display("FAIL rst_ireq_valid got %b exp 0", ireq_valid_o);
    end
    if (pc_advance_o !== 1'b0) begin
      bad++; $display("FAIL rst_pc_advance got %b exp 0", pc_advance_o);
    end
    if (dec_valid_o !== 1'b0) begin
      bad++; $display("FAIL rst_dec_valid got %b exp 0", dec_valid_o);
    end
    if (dec_exc_o !== 1'b0) begin
      bad++; $display("FAIL rst_dec_exc got %b exp 0", dec_exc_o);
    end
    if (dec_pc_o !== RPC) begin
      bad++; $display("FAIL rst_dec_pc got %h exp %h", dec_pc_o, RPC);
    end
    if (dec_instr_o !== 32'h0) begin
      bad++; $display("FAIL rst_dec_instr got %h exp 0", dec_instr_o);
    end
    if (ireq_addr_o !== 64'h0) begin
      bad++; $display("FAIL rst_ireq_addr got %h exp 0", ireq_addr_o);
    end
  endtask

  task automatic test_basic_fetch();
    cyc(0, A, 0, 0, 0, 0);
    total++;
    if (ireq_valid_o !== 1'b0) begin
      bad++; $display("FAIL bf_idle_req got %b exp 0", ireq_valid_o);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, A, 0, (i == 2), INS, 0);
      total += 3;
      if (ireq_valid_o !== 1'b1) begin
        bad++; $display("FAIL bf_req_valid got %b exp 1", ireq_valid_o);
      end
      if (ireq_addr_o !== A) begin
        bad++; $display("FAIL bf_req_addr got %h exp %h", ireq_addr_o, A);
      end
      if (pc_advance_o !== (i == 2)) begin
        bad++; $display("FAIL bf_adv got %b exp %b", pc_advance_o, (i == 2));
      end
    end
    cyc(0, A + 4, 0, 0, 0, 0);
    total += 4;
    if (dec_valid_o !== 1'b1) begin
      bad++; $display("FAIL bf_dec_valid got %b exp 1", dec_valid_o);
    end
    if (dec_instr_o !== INS) begin
      bad++; $display("FAIL bf_dec_instr got %h exp %h", dec_instr_o, INS);
    end
    if (dec_pc_o !== A) begin
      bad++; $display("FAIL bf_dec_pc got %h exp %h", dec_pc_o, A);
    end
    if (pc_advance_o !== 1'b0) begin
      bad++; $display("FAIL bf_adv_hold got %b exp 0", pc_advance_o);
    end
  endtask

  task automatic test_decode_stall();
    for (int i = 0; i < 5; i++) begin
      cyc(0, A + 4, 0, 0, 0, 0);
      total += 5;
      if (dec_valid_o !== 1'b1) begin
        bad++; $display("FAIL st_dec_valid got %b exp 1", dec_valid_o);
      end
      if (dec_pc_o !== A) begin
        bad++; $display("FAIL st_dec_pc got %h exp %h", dec_pc_o, A);
      end
      if (dec_instr_o !== INS) begin
        bad++; $display("FAIL st_dec_instr got %h exp %h", dec_instr_o, INS);
      end
      if (ireq_valid_o !== 1'b0) begin
        bad++; $display("FAIL st_req got %b exp 0", ireq_valid_o);
      end
      if (pc_advance_o !== 1'b0) begin
        bad++; $display("FAIL st_adv got %b exp 0", pc_advance_o);
      end
    end
    cyc(0, A + 4, 0, 0, 0, 1);
    cyc(0, A + 4, 0, 0, 0, 0);
    total += 3;
    if (ireq_valid_o !== 1'b1) begin
      bad++; $display("FAIL st_next_req got %b exp 1", ireq_valid_o);
    end
    if (ireq_addr_o !== A + 4) begin
      bad++; $display("FAIL st_next_addr got %h exp %h", ireq_addr_o, A + 4);
    end
    if (dec_valid_o !== 1'b0) begin
      bad++; $display("FAIL st_dec_drop got %b exp 0", dec_valid_o);
    end
  endtask

  task automatic test_redirect_req();
    logic [63:0] t = 64'h8000_0100;
    cyc(0, A + 4, 1, 0, 0, 0);
    total++;
    if (pc_advance_o !== 1'b0) begin
      bad++; $display("FAIL rr_adv0 got %b exp 0", pc_advance_o);
    end
    cyc(0, t, 0, 1, 32'hDEAD_BEEF, 0);
    total += 4;
    if (ireq_valid_o !== 1'b1) begin
      bad++; $display("FAIL rr_disc_req got %b exp 1", ireq_valid_o);
    end
    if (ireq_addr_o !== A + 4) begin
      bad++; $display("FAIL rr_disc_addr got %h exp %h", ireq_addr_o, A + 4);
    end
    if (pc_advance_o !== 1'b0) begin
      bad++; $display("FAIL rr_adv1 got %b exp 0", pc_advance_o);
    end
    if (dec_valid_o !== 1'b0) begin
      bad++; $display("FAIL rr_dec1 got %b exp 0", dec_valid_o);
    end
    cyc(0, t, 0, 0, 0, 0);
    total += 2;
    if (ireq_valid_o !== 1'b0) begin
      bad++; $display("FAIL rr_idle_req got %b exp 0", ireq_valid_o);
    end
    if (dec_valid_o !== 1'b0) begin
      bad++; $display("FAIL rr_dec2 got %b exp 0", dec_valid_o);
    end
    cyc(0, t, 0, 1, mem(t), 0);
    total += 3;
    if (ireq_addr_o !== t || ireq_valid_o !== 1'b1) begin
      bad++; $display("FAIL rr_new_addr got %h/%b exp %h/1", ireq_addr_o, ireq_valid_o, t);
    end
    if (dec_valid_o !== 1'b0) begin
      bad++; $display("FAIL rr_dec3 got %b exp 0", dec_valid_o);
    end
    if (pc_advance_o !== 1'b1) begin
      bad++; $display("FAIL rr_adv_new got %b exp 1", pc_advance_o);
    end
  endtask

  task automatic test_redirect_hold();
    logic [63:0] t2 = 64'h8000_0200;
    cyc(0, 64'h8000_0104, 1, 0, 0, 1);
    total += 2;
    if (dec_valid_o !== 1'b1) begin
      bad++; $display("FAIL rh_dec_valid got %b exp 1", dec_valid_o);
    end
    if (pc_advance_o !== 1'b0) begin
      bad++; $display("FAIL rh_adv got %b exp 0", pc_advance_o);
    end
    cyc(0, t2, 0, 0, 0, 0);
    total += 2;
    if (dec_valid_o !== 1'b0) begin
      bad++; $display("FAIL rh_dec_drop got %b exp 0", dec_valid_o);
    end
    if (ireq_valid_o !== 1'b0) begin
      bad++; $display("FAIL rh_idle_req got %b exp 0", ireq_valid_o);
    end
    cyc(0, t2, 0, 0, 0, 0);
    total++;
    if (ireq_valid_o !== 1'b1 || ireq_addr_o !== t2) begin
      bad++; $display("FAIL rh_req got %b/%h exp 1/%h", ireq_valid_o, ireq_addr_o, t2);
    end
  endtask

  task automatic test_reset_mid_req();
    cyc(1, 64'h8000_0200, 0, 1, 32'h1234_5678, 0);
    cyc(0, 64'h8000_0200, 1, 0, 0, 0);
    total += 6;
    if (ireq_valid_o !== 1'b0) begin
      bad++; $display("FAIL rm_req got %b exp 0", ireq_valid_o);
    end
    if (dec_valid_o !== 1'b0) begin
      bad++; $display("FAIL rm_dec_valid got %b exp 0", dec_valid_o);
    end
    if (dec_pc_o !== RPC) begin
      bad++; $display("FAIL rm_dec_pc got %h exp %h", dec_pc_o, RPC);
    end
    if (dec_instr_o !== 32'h0) begin
      bad++; $display("FAIL rm_dec_instr got %h exp 0", dec_instr_o);
    end
    if (ireq_addr_o !== 64'h0) begin
      bad++; $display("FAIL rm_addr got %h exp 0", ireq_addr_o);
    end
    if (pc_advance_o !== 1'b0) begin
      bad++; $display("FAIL rm_adv got %b exp 0", pc_advance_o);
    end
    cyc(0, 64'h8000_0200, 1, 0, 0, 0);
    total++;
    if (dec_valid_o !== 1'b0) begin
      bad++; $display("FAIL rm_dec_valid2 got %b exp 0", dec_valid_o);
    end
  endtask

`ifdef IFETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    logic [63:0] m = 64'h8000_0002;
    cyc(0, m, 0, 0, 0, 0);
    cyc(0, m, 0, 0, 0, 0);
    total += 6;
    if (ireq_valid_o !== 1'b0) begin
      bad++; $display("FAIL ma_req got %b exp 0", ireq_valid_o);
    end
    if (dec_valid_o !== 1'b1) begin
      bad++; $display("FAIL ma_dec_valid got %b exp 1", dec_valid_o);
    end
    if (dec_exc_o !== 1'b1) begin
      bad++; $display("FAIL ma_exc got %b exp 1", dec_exc_o);
    end
    if (dec_instr_o !== 32'h0000_0013) begin
      bad++; $display("FAIL ma_instr got %h exp 00000013", dec_instr_o);
    end
    if (dec_pc_o !== m) begin
      bad++; $display("FAIL ma_pc got %h exp %h", dec_pc_o, m);
    end
    if (pc_advance_o !== 1'b0) begin
      bad++; $display("FAIL ma_adv got %b exp 0", pc_advance_o);
    end
    cyc(0, 64'h8000_0300, 1, 0, 0, 0);
  endtask
`endif

  // Model: an outstanding request (possibly doomed), or a held
  // instruction, or neither; plus the PC register and a memory.
  task automatic test_random();
    logic [63:0] env_pc = A;
    logic        busy = 0, drop = 0, held = 0;
    logic [63:0] raddr = '0, hpc = '0;
    logic [31:0] hins = '0;
    int          wait_n = 1;
    int          adv_n = 0, deliv_n = 0;
    logic        redir, rdy, dok, adv;
    logic [63:0] tgt;
    cyc(1, env_pc, 0, 0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      redir = ($urandom_range(0, 7) == 0);
      rdy = $urandom_range(0, 1);
      tgt = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_fffc)};
      dok = busy && (wait_n == 0);
      cyc(0, env_pc, redir, dok, mem(raddr), rdy);
      adv = busy && !drop && dok && !redir;
      total += 5;
      if (ireq_valid_o !== busy) begin
        bad++; $display("FAIL rnd_req c=%0d got %b exp %b", c, ireq_valid_o, busy);
      end
      if (busy && ireq_addr_o !== raddr) begin
        bad++; $display("FAIL rnd_addr c=%0d got %h exp %h", c, ireq_addr_o, raddr);
      end
      if (dec_valid_o !== held) begin
        bad++; $display("FAIL rnd_dec_valid c=%0d got %b exp %b", c, dec_valid_o, held);
      end
      if (dec_pc_o !== (held ? hpc : RPC)) begin
        bad++; $display("FAIL rnd_dec_pc c=%0d got %h exp %h", c, dec_pc_o, held ? hpc : RPC);
      end
      if (pc_advance_o !== adv) begin
        bad++; $display("FAIL rnd_adv c=%0d got %b exp %b", c, pc_advance_o, adv);
      end
      if (held) begin
        total += 2;
        if (dec_instr_o !== hins) begin
          bad++; $display("FAIL rnd_instr c=%0d got %h exp %h", c, dec_instr_o, hins);
        end
        if (dec_exc_o !== 1'b0) begin
          bad++; $display("FAIL rnd_exc c=%0d got %b exp 0", c, dec_exc_o);
        end
      end
      if (adv) adv_n++;
      if (busy) begin
        if (dok) begin
          busy = 0;
          if (adv) begin
            held = 1; hpc = raddr; hins = mem(raddr);
          end
          wait_n = $urandom_range(0, 3);
        end else begin
          wait_n--;
          if (redir) drop = 1;
        end
      end else if (held) begin
        if (redir) held = 0;
        else if (rdy) begin
          deliv_n++;
          held = 0; busy = 1; drop = 0; raddr = env_pc;
        end
      end else if (!redir) begin
        busy = 1; drop = 0; raddr = env_pc;
      end
      if (redir) env_pc = tgt;
      else if (adv) env_pc = env_pc + 4;
    end
    total++;
    if (deliv_n == 0 || deliv_n > adv_n) begin
      bad++; $display("FAIL rnd_deliveries got %0d exp 1..%0d", deliv_n, adv_n);
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_decode_stall();
    test_redirect_req();
    test_redirect_hold();
    test_reset_mid_req();
`ifdef IFETCH_MISALIGN_CHECK_EN
    test_misalign();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
